// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared definitions for the WS2812 chain driver.
//   - ws_state_e   : frame sequencer states (IDLE / SEND / LATCH)
//   - REG_*        : APB word indices (PADDR[8:2])
//   - CTRL_*/STAT_*: bit positions inside CTRL and STATUS
//   - scale_grb()  : brightness scaling, only present when the optional
//                    feature macro WS2812_BRIGHTNESS_EN is defined.
package ws2812_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_LATCH = 2'd2
    } ws_state_e;

    localparam logic [6:0] REG_CTRL       = 7'd0;
    localparam logic [6:0] REG_STATUS     = 7'd1;
    localparam logic [6:0] REG_BRIGHT     = 7'd2;
    localparam logic [6:0] REG_COLOR_BASE = 7'd64;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_CONT_BIT   = 1;
    localparam int STAT_BUSY_BIT   = 0;
    localparam int STAT_LATCH_BIT  = 1;
    localparam int STAT_FRAMES_LSB = 8;

`ifdef WS2812_BRIGHTNESS_EN
    // (c * (b + 1)) >> 8 ; b = 255 leaves c unchanged. Max product 255*256 fits 16 bits.
    function automatic logic [7:0] scale_byte(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] prod;
        prod = {8'd0, c} * ({8'd0, b} + 16'd1);
        return prod[15:8];
    endfunction

    function automatic logic [23:0] scale_grb(input logic [23:0] c, input logic [7:0] b);
        return {scale_byte(c[23:16], b), scale_byte(c[15:8], b), scale_byte(c[7:0], b)};
    endfunction
`endif

endpackage

// File: rtl/ws2812_bit_encoder.sv
// ws2812_bit_encoder: times one WS2812 data bit slot.
//   clk_i      : clock
//   rst_ni     : synchronous active-low reset
//   en_i       : sequencer is in SEND; the phase counter runs
//   start_i    : a new frame begins; phase restarts at 0
//   bit_i      : value of the bit being sent
//   led_o      : registered line level (high for T1H or T0H cycles of each slot)
//   bit_done_o : combinational pulse in the last cycle of a slot
module ws2812_bit_encoder #(
    parameter int CLK_PER_BIT = 125,
    parameter int T0H_CLKS    = 40,
    parameter int T1H_CLKS    = 80
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic start_i,
    input  logic bit_i,
    output logic led_o,
    output logic bit_done_o
);

    localparam int PW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(CLK_PER_BIT - 1);
    localparam logic [PW-1:0] PH_ONE  = PW'(1);
    localparam logic [PW-1:0] T0H     = PW'(T0H_CLKS);
    localparam logic [PW-1:0] T1H     = PW'(T1H_CLKS);

    logic [PW-1:0] phase_q, phase_d;
    logic          led_q, led_d;
    logic [PW-1:0] high_len_s;

    // Next phase and next line level; the level is registered so LED follows the slot by one edge.
    always_comb begin
        phase_d    = phase_q;
        led_d      = 1'b0;
        high_len_s = bit_i ? T1H : T0H;
        if (start_i) begin
            phase_d = '0;
            led_d   = 1'b0;
        end else if (en_i) begin
            led_d = (phase_q < high_len_s);
            if (phase_q == PH_LAST) begin
                phase_d = '0;
            end else begin
                phase_d = phase_q + PH_ONE;
            end
        end else begin
            phase_d = '0;
            led_d   = 1'b0;
        end
    end

    // Phase counter and output level register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            phase_q <= '0;
            led_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            led_q   <= led_d;
        end
    end

    assign bit_done_o = en_i & (phase_q == PH_LAST);
    assign led_o      = led_q;

endmodule

// File: rtl/ws2812_chain_apb.sv
// ws2812_chain_apb: APB3 slave streaming NUM_LEDS GRB words to a WS2812 chain.
//   PCLK/PRESERN        : clock, synchronous active-low reset
//   PSEL/PENABLE/PWRITE : APB control; access strobe = PSEL & PENABLE
//   PADDR[8:2]          : word index (0 CTRL, 1 STATUS, 2 BRIGHT, 64+i COLOR[i])
//   PWDATA/PRDATA       : write / combinational read data
//   PREADY              : always 1
//   PSLVERR             : unmapped index, STATUS write or COLOR beyond NUM_LEDS
//   LED                 : serial data line
// Optional feature macro: WS2812_BRIGHTNESS_EN (BRIGHT register and colour scaling).
module ws2812_chain_apb
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS    = 8,
    parameter int CLK_PER_BIT = 125,
    parameter int T0H_CLKS    = 40,
    parameter int T1H_CLKS    = 80,
    parameter int RESET_CLKS  = 6000
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        LED
);

    localparam int LW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int CW = (RESET_CLKS > 1) ? $clog2(RESET_CLKS) : 1;
    localparam logic [LW-1:0] LED_LAST   = LW'(NUM_LEDS - 1);
    localparam logic [LW-1:0] LED_ONE    = LW'(1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(RESET_CLKS - 1);
    localparam logic [CW-1:0] LATCH_ONE  = CW'(1);
    localparam logic [6:0]    NUM_LEDS_W = 7'(NUM_LEDS);

    ws_state_e     state_q;
    logic [LW-1:0] led_idx_q;
    logic [4:0]    bit_idx_q;
    logic [23:0]   shift_q;
    logic [CW-1:0] latch_cnt_q;
    logic [7:0]    frames_q;
    logic          cont_q;
    logic [23:0]   colors_q [NUM_LEDS];
`ifdef WS2812_BRIGHTNESS_EN
    logic [7:0]    bright_q;
`endif

    logic          strobe_s, err_s, wr_ok_s, color_hit_s;
    logic [6:0]    idx_s;
    logic [5:0]    col_off_s;
    logic [LW-1:0] col_sel_s;
    logic [31:0]   rdata_s;
    logic          start_acc_s, latch_done_s, enc_start_s, bit_done_s, led_s;
    logic [LW-1:0] snap_idx_s;
    logic [23:0]   snap_raw_s, snap_d;
    logic          unused_s;

    assign unused_s = ^{PADDR[31:9], PADDR[1:0], PWDATA[31:24]};

    // Address decode and error classification.
    always_comb begin
        strobe_s    = PSEL & PENABLE;
        idx_s       = PADDR[8:2];
        col_off_s   = idx_s[5:0];
        col_sel_s   = col_off_s[LW-1:0];
        color_hit_s = idx_s[6] && ({1'b0, col_off_s} < NUM_LEDS_W);
        case (idx_s)
            REG_CTRL:   err_s = 1'b0;
            REG_BRIGHT: err_s = 1'b0;
            REG_STATUS: err_s = PWRITE;
            default:    err_s = !color_hit_s;
        endcase
        wr_ok_s = strobe_s & PWRITE & ~err_s;
    end

    // Read data mux; unmapped and out-of-range words read 0.
    always_comb begin
        rdata_s = 32'd0;
        case (idx_s)
            REG_CTRL: begin
                rdata_s[CTRL_CONT_BIT] = cont_q;
            end
            REG_STATUS: begin
                rdata_s[STAT_BUSY_BIT]           = (state_q != ST_IDLE);
                rdata_s[STAT_LATCH_BIT]          = (state_q == ST_LATCH);
                rdata_s[STAT_FRAMES_LSB +: 8]    = frames_q;
            end
            REG_BRIGHT: begin
`ifdef WS2812_BRIGHTNESS_EN
                rdata_s[7:0] = bright_q;
`else
                rdata_s = 32'd0;
`endif
            end
            default: begin
                if (color_hit_s) begin
                    rdata_s = {8'd0, colors_q[col_sel_s]};
                end else begin
                    rdata_s = 32'd0;
                end
            end
        endcase
    end

    // Snapshot source: next LED while sending, LED 0 when a frame (re)starts.
    always_comb begin
        if (state_q == ST_SEND) begin
            snap_idx_s = led_idx_q + LED_ONE;
        end else begin
            snap_idx_s = '0;
        end
        snap_raw_s = colors_q[snap_idx_s];
`ifdef WS2812_BRIGHTNESS_EN
        snap_d = scale_grb(snap_raw_s, bright_q);
`else
        snap_d = snap_raw_s;
`endif
    end

    // START is honoured only from IDLE; continuous mode re-enters SEND at latch end.
    always_comb begin
        start_acc_s  = wr_ok_s && (idx_s == REG_CTRL) && PWDATA[CTRL_START_BIT] && (state_q == ST_IDLE);
        latch_done_s = (state_q == ST_LATCH) && (latch_cnt_q == LATCH_LAST);
        enc_start_s  = start_acc_s | (latch_done_s & cont_q);
    end

    // Frame sequencer: bit/LED indices, shift snapshot, latch timer and frame counter.
    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            state_q     <= ST_IDLE;
            led_idx_q   <= '0;
            bit_idx_q   <= 5'd23;
            shift_q     <= 24'd0;
            latch_cnt_q <= '0;
            frames_q    <= 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_acc_s) begin
                        state_q   <= ST_SEND;
                        led_idx_q <= '0;
                        bit_idx_q <= 5'd23;
                        shift_q   <= snap_d;
                    end
                end
                ST_SEND: begin
                    if (bit_done_s) begin
                        if (bit_idx_q == 5'd0) begin
                            if (led_idx_q == LED_LAST) begin
                                state_q     <= ST_LATCH;
                                latch_cnt_q <= '0;
                            end else begin
                                led_idx_q <= led_idx_q + LED_ONE;
                                bit_idx_q <= 5'd23;
                                shift_q   <= snap_d;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q - 5'd1;
                        end
                    end
                end
                ST_LATCH: begin
                    if (latch_done_s) begin
                        frames_q    <= frames_q + 8'd1;
                        latch_cnt_q <= '0;
                        if (cont_q) begin
                            state_q   <= ST_SEND;
                            led_idx_q <= '0;
                            bit_idx_q <= 5'd23;
                            shift_q   <= snap_d;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        latch_cnt_q <= latch_cnt_q + LATCH_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Software-visible registers: CONT and the colour words.
    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            cont_q <= 1'b0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                colors_q[i] <= 24'd0;
            end
        end else begin
            if (wr_ok_s && (idx_s == REG_CTRL)) begin
                cont_q <= PWDATA[CTRL_CONT_BIT];
            end
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (wr_ok_s && color_hit_s && (col_sel_s == LW'(i))) begin
                    colors_q[i] <= PWDATA[23:0];
                end
            end
        end
    end

`ifdef WS2812_BRIGHTNESS_EN
    // Brightness register, full scale after reset.
    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            bright_q <= 8'd255;
        end else if (wr_ok_s && (idx_s == REG_BRIGHT)) begin
            bright_q <= PWDATA[7:0];
        end
    end
`endif

    ws2812_bit_encoder #(
        .CLK_PER_BIT (CLK_PER_BIT),
        .T0H_CLKS    (T0H_CLKS),
        .T1H_CLKS    (T1H_CLKS)
    ) u_enc (
        .clk_i      (PCLK),
        .rst_ni     (PRESERN),
        .en_i       (state_q == ST_SEND),
        .start_i    (enc_start_s),
        .bit_i      (shift_q[bit_idx_q]),
        .led_o      (led_s),
        .bit_done_o (bit_done_s)
    );

    assign PRDATA  = rdata_s;
    assign PREADY  = 1'b1;
    assign PSLVERR = strobe_s & err_s;
    assign LED     = led_s;

endmodule

// File: tb/tb_ws2812_chain_apb.sv
// Scoreboard bench for ws2812_chain_apb (NUM_LEDS=2, CLK_PER_BIT=10, T0H=3, T1H=7, RESET_CLKS=20).
// APB expectations and expected LED words are queued by the stimulus; two monitor
// processes pop and compare when the DUT presents an access or completes a 24-bit word.
module tb_ws2812_chain_apb;

    localparam int NL  = 2;
    localparam int CPB = 10;
    localparam int T0  = 3;
    localparam int T1  = 7;
    localparam int RC  = 20;

    localparam logic [31:0] A_CTRL   = 32'h0000_0000;
    localparam logic [31:0] A_STATUS = 32'h0000_0004;
    localparam logic [31:0] A_BRIGHT = 32'h0000_0008;
    localparam logic [31:0] A_W5     = 32'h0000_0014;
    localparam logic [31:0] A_COL0   = 32'h0000_0100;
    localparam logic [31:0] A_COL1   = 32'h0000_0104;
    localparam logic [31:0] A_COL2   = 32'h0000_0108;

    logic        PCLK    = 1'b0;
    logic        PRESERN = 1'b0;
    logic        PSEL    = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE  = 1'b0;
    logic [31:0] PADDR   = 32'd0;
    logic [31:0] PWDATA  = 32'd0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        LED;

    ws2812_chain_apb #(
        .NUM_LEDS    (NL),
        .CLK_PER_BIT (CPB),
        .T0H_CLKS    (T0),
        .T1H_CLKS    (T1),
        .RESET_CLKS  (RC)
    ) dut (
        .PCLK    (PCLK),
        .PRESERN (PRESERN),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .LED     (LED)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct packed {
        logic        is_rd;
        logic        err;
        logic [31:0] data;
    } apb_exp_t;

    apb_exp_t    apb_q[$];
    logic [23:0] word_q[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic wait_until(input int n);
        while (cyc < n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    task automatic apb_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] exp, input logic e);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = a;
        PWDATA  = d;
        @(posedge PCLK);
        #1;
        apb_q.push_back('{is_rd: !wr, err: e, data: exp});
        PENABLE = 1'b1;
        @(posedge PCLK);
        #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
    endtask

    task automatic apb_wr(input logic [31:0] a, input logic [31:0] d, input logic e);
        apb_xfer(1'b1, a, d, 32'd0, e);
    endtask

    task automatic apb_rd(input logic [31:0] a, input logic [31:0] exp, input logic e);
        apb_xfer(1'b0, a, 32'd0, exp, e);
    endtask

    // APB monitor: every access phase pops one expectation.
    initial begin
        apb_exp_t e;
        forever begin
            @(negedge PCLK);
            if (PSEL && PENABLE) begin
                if (apb_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL apb_unexpected: access to 0x%08h with no expectation", PADDR);
                end else begin
                    e = apb_q.pop_front();
                    chk("pslverr", {31'd0, PSLVERR}, {31'd0, e.err});
                    if (e.is_rd) begin
                        chk("prdata", PRDATA, e.data);
                    end
                end
            end
        end
    end

    // LED monitor: decodes pulse widths into bits, compares each 24-bit word.
    initial begin
        int          hi_cnt;
        int          nbits;
        logic [23:0] acc;
        hi_cnt = 0;
        nbits  = 0;
        acc    = 24'd0;
        forever begin
            @(negedge PCLK);
            if (!PRESERN) begin
                hi_cnt = 0;
                nbits  = 0;
            end else if (LED) begin
                hi_cnt = hi_cnt + 1;
            end else if (hi_cnt > 0) begin
                n_checks++;
                if (hi_cnt == T1) begin
                    acc = {acc[22:0], 1'b1};
                end else if (hi_cnt == T0) begin
                    acc = {acc[22:0], 1'b0};
                end else begin
                    n_fails++;
                    acc = {acc[22:0], 1'b0};
                    $display("FAIL led_pulse: high for %0d cycles, required %0d or %0d", hi_cnt, T0, T1);
                end
                hi_cnt = 0;
                nbits  = nbits + 1;
                if (nbits == 24) begin
                    nbits = 0;
                    if (word_q.size() == 0) begin
                        n_checks++;
                        n_fails++;
                        $display("FAIL led_word: unexpected word 0x%06h", acc);
                    end else begin
                        chk("led_word", {8'd0, acc}, {8'd0, word_q.pop_front()});
                    end
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        PRESERN = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        PRESERN = 1'b1;

        // Reset state
        chk("led_reset", {31'd0, LED}, 32'd0);
        apb_rd(A_STATUS, 32'd0, 1'b0);
        apb_rd(A_CTRL,   32'd0, 1'b0);
        apb_rd(A_COL0,   32'd0, 1'b0);
        apb_rd(A_COL1,   32'd0, 1'b0);

        // 1: single frame, latency and frame timing
        apb_wr(A_COL0, 32'h00A5_0000, 1'b0);
        apb_wr(A_COL1, 32'h0000_0001, 1'b0);
        word_q.push_back(24'hA50000);
        word_q.push_back(24'h000001);
        apb_wr(A_CTRL, 32'h1, 1'b0);
        k = cyc;
        @(negedge PCLK);
        chk("led_before_rise", {31'd0, LED}, 32'd0);
        @(negedge PCLK);
        chk("led_first_rise", {31'd0, LED}, 32'd1);
        wait_until(k + 478);
        apb_rd(A_STATUS, 32'h0000_0001, 1'b0);   // last bit slot
        apb_rd(A_STATUS, 32'h0000_0003, 1'b0);   // in latch
        wait_until(k + 498);
        apb_rd(A_STATUS, 32'h0000_0003, 1'b0);   // final latch cycle
        apb_rd(A_STATUS, 32'h0000_0100, 1'b0);   // idle, one frame sent

        // 2: readback and error responses
        apb_rd(A_COL1, 32'h0000_0001, 1'b0);
        apb_wr(A_COL2, 32'h0012_3456, 1'b1);
        apb_rd(A_COL0, 32'h00A5_0000, 1'b0);
        apb_wr(A_W5, 32'hFFFF_FFFF, 1'b1);
        apb_wr(A_STATUS, 32'hFFFF_FFFF, 1'b1);
        apb_rd(A_W5, 32'd0, 1'b1);
        apb_rd(A_STATUS, 32'h0000_0100, 1'b0);
        apb_rd(A_CTRL, 32'd0, 1'b0);
        apb_wr(A_COL0, 32'hFFA5_0000, 1'b0);
        apb_rd(A_COL0, 32'h00A5_0000, 1'b0);

        // 3: mid-frame START ignored, snapshot timing of colour writes
        word_q.push_back(24'hA50000);
        word_q.push_back(24'hFFFFFF);
        apb_wr(A_CTRL, 32'h1, 1'b0);
        k = cyc;
        wait_until(k + 50);
        apb_wr(A_COL1, 32'h00FF_FFFF, 1'b0);
        wait_until(k + 100);
        apb_wr(A_CTRL, 32'h1, 1'b0);
        wait_until(k + 300);
        apb_wr(A_COL0, 32'h0012_3456, 1'b0);
        wait_until(k + 498);
        apb_rd(A_STATUS, 32'h0000_0103, 1'b0);
        apb_rd(A_STATUS, 32'h0000_0200, 1'b0);

        // 4: continuous mode, then clear CONT mid-frame
        repeat (4) begin
            word_q.push_back(24'h123456);
            word_q.push_back(24'hFFFFFF);
        end
        apb_wr(A_CTRL, 32'h3, 1'b0);
        k = cyc;
        apb_rd(A_CTRL, 32'h0000_0002, 1'b0);
        wait_until(k + 1498);
        apb_rd(A_STATUS, 32'h0000_0403, 1'b0);
        apb_rd(A_STATUS, 32'h0000_0501, 1'b0);
        wait_until(k + 1600);
        apb_wr(A_CTRL, 32'h0, 1'b0);
        wait_until(k + 1998);
        apb_rd(A_STATUS, 32'h0000_0503, 1'b0);
        apb_rd(A_STATUS, 32'h0000_0600, 1'b0);

        // 5: reset during the high phase of bit slot 5
        apb_wr(A_COL0, 32'h00FF_FFFF, 1'b0);
        apb_wr(A_CTRL, 32'h1, 1'b0);
        k = cyc;
        wait_until(k + 52);
        PRESERN = 1'b0;
        @(negedge PCLK);
        chk("led_before_reset", {31'd0, LED}, 32'd1);
        @(negedge PCLK);
        chk("led_after_reset", {31'd0, LED}, 32'd0);
        @(posedge PCLK);
        #1;
        PRESERN = 1'b1;
        apb_rd(A_STATUS, 32'd0, 1'b0);
        apb_rd(A_COL0, 32'd0, 1'b0);
        apb_rd(A_COL1, 32'd0, 1'b0);
        apb_rd(A_CTRL, 32'd0, 1'b0);

        // 6: brightness
`ifdef WS2812_BRIGHTNESS_EN
        apb_rd(A_BRIGHT, 32'h0000_00FF, 1'b0);
        apb_wr(A_BRIGHT, 32'h0000_007F, 1'b0);
        apb_rd(A_BRIGHT, 32'h0000_007F, 1'b0);
        word_q.push_back(24'h7F4000);
        word_q.push_back(24'h000000);
`else
        apb_wr(A_BRIGHT, 32'h0000_007F, 1'b0);
        apb_rd(A_BRIGHT, 32'd0, 1'b0);
        word_q.push_back(24'hFF8000);
        word_q.push_back(24'h000001);
`endif
        apb_wr(A_COL0, 32'h00FF_8000, 1'b0);
        apb_wr(A_COL1, 32'h0000_0001, 1'b0);
        apb_wr(A_CTRL, 32'h1, 1'b0);
        k = cyc;
        wait_until(k + 502);
        apb_rd(A_STATUS, 32'h0000_0100, 1'b0);

        @(negedge PCLK);
        chk("led_words_left", 32'(word_q.size()), 32'd0);
        chk("apb_left", 32'(apb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
